// File: rtl/sm_product_accumulator_pkg.sv
// Shared types and sign-magnitude helpers for the product-accumulate layer stage.
// Other layer stages reuse the conversion functions.
package sm_product_accumulator_pkg;

  localparam int SM_PROD_W   = 16;
  localparam int SM_ACT_W    = 8;
  localparam int ACT_MAG_MAX = 127;
  localparam int PROD_MAG_W  = 14;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_RQNT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Wide enough for any legal accumulator width; negative zero maps to 0.
  function automatic logic signed [32:0] sm_to_tc(input logic sign,
                                                  input logic [PROD_MAG_W-1:0] mag);
    logic signed [32:0] m;
    m = signed'({19'b0, mag});
    return sign ? -m : m;
  endfunction

  function automatic logic [SM_ACT_W-1:0] tc_to_sm(input logic neg,
                                                   input logic [SM_ACT_W-2:0] mag);
    return {neg && (mag != '0), mag};
  endfunction

endpackage

// File: rtl/sm_requant.sv
// Combinational requantizer: round-half-up, arithmetic shift, optional ReLU,
// and saturation to an 8-bit sign-magnitude activation.
module sm_requant
  import sm_product_accumulator_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0]    acc_i,
  input  logic        [3:0]          shift_i,
  input  logic                       relu_i,
  output logic        [SM_ACT_W-1:0] data_o
);

  logic signed [ACC_W:0] acc_ext;
  logic        [ACC_W:0] rnd;
  logic signed [ACC_W:0] r;
  logic        [ACC_W:0] abs_r;
  logic                  neg;
  logic [SM_ACT_W-2:0]   mag;

  always_comb begin
    acc_ext = {acc_i[ACC_W-1], acc_i};
    // Half an LSB of the output; zero when no shift is applied.
    rnd     = ((ACC_W+1)'(1) << shift_i) >> 1;
    r       = signed'(acc_ext + rnd) >>> shift_i;
    if (relu_i && r[ACC_W]) begin
      r = '0;
    end
    neg   = r[ACC_W];
    abs_r = neg ? unsigned'(-r) : unsigned'(r);
    mag   = (abs_r > (ACC_W+1)'(ACT_MAG_MAX)) ? (SM_ACT_W-1)'(ACT_MAG_MAX)
                                              : abs_r[SM_ACT_W-2:0];
    data_o = tc_to_sm(neg, mag);
  end

endmodule

// File: rtl/sm_product_accumulator.sv
// Accumulates sign-magnitude products per group into a saturating accumulator
// and emits one requantized sign-magnitude activation per group.
module sm_product_accumulator
  import sm_product_accumulator_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SM_PROD_W-1:0] in_data,
  input  logic                 in_last,
  input  logic [3:0]           cfg_shift,
  input  logic                 cfg_relu,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SM_ACT_W-1:0]  out_data,
  output logic                 acc_ovf
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      first_q, first_d;
  logic                      ovf_q, ovf_d;
  logic [3:0]                shift_q, shift_d;
  logic                      relu_q, relu_d;
  logic [SM_ACT_W-1:0]       out_data_q, out_data_d;
  logic                      acc_ovf_q, acc_ovf_d;

  logic                      beat;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   base;
  logic signed [ACC_W:0]     sum;
  logic [SM_ACT_W-1:0]       rq_data;
  logic                      unused_bit14;

  // Bit 14 of a product is always zero from the multiplier and carries no value.
  assign unused_bit14 = in_data[14];

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;
  assign acc_ovf   = acc_ovf_q;
  assign beat      = in_valid & in_ready;
  assign term      = ACC_W'(sm_to_tc(in_data[15], in_data[PROD_MAG_W-1:0]));

  sm_requant #(.ACC_W(ACC_W)) u_requant (
    .acc_i   (acc_q),
    .shift_i (shift_q),
    .relu_i  (relu_q),
    .data_o  (rq_data)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    first_d    = first_q;
    ovf_d      = ovf_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    out_data_d = out_data_q;
    acc_ovf_d  = acc_ovf_q;
    base       = first_q ? '0 : acc_q;
    sum        = {base[ACC_W-1], base} + {term[ACC_W-1], term};

    case (state_q)
      ST_ACC: begin
        if (beat) begin
          if (first_q) begin
            shift_d = cfg_shift;
            relu_d  = cfg_relu;
            ovf_d   = 1'b0;
          end
          // Sign bits disagree: the sum left the ACC_W range.
          if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          first_d = in_last;
          if (in_last) begin
            state_d = ST_RQNT;
          end
        end
      end
      ST_RQNT: begin
        out_data_d = rq_data;
        acc_ovf_d  = ovf_q;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      first_q    <= 1'b1;
      ovf_q      <= 1'b0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      out_data_q <= '0;
      acc_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      first_q    <= first_d;
      ovf_q      <= ovf_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      out_data_q <= out_data_d;
      acc_ovf_q  <= acc_ovf_d;
    end
  end

endmodule

// File: tb/tb_sm_product_accumulator.sv
// Directed self-checking bench for sm_product_accumulator with hand-computed
// expected activations.
module tb_sm_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [3:0]  cfg_shift;
  logic        cfg_relu;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        acc_ovf;

  int checks   = 0;
  int failures = 0;

  sm_product_accumulator #(.ACC_W(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .acc_ovf   (acc_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'h0000;
  endtask

  // Called right after the edge that accepted the last beat.
  task automatic finish_group(input string tag, input logic [7:0] exp_d, input logic exp_o);
    chk({tag, "_rqnt_valid"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
    chk({tag, "_ovf"}, 32'(acc_ovf), 32'(exp_o));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0;
    cfg_shift = 4'd0; cfg_relu = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_acc_ovf", 32'(acc_ovf), 32'd0);
    rst = 1'b0;
    tick();

    // 5 - 3 = 2
    beat(16'h0005, 1'b0);
    beat(16'h8003, 1'b1);
    finish_group("acc2", 8'h02, 1'b0);

    // (100+8)>>4 = 6; cfg changes and a stray in_last mid-group are ignored
    cfg_shift = 4'd4;
    beat(16'h0064, 1'b0);
    cfg_shift = 4'd0;
    cfg_relu  = 1'b1;
    in_last   = 1'b1;
    tick();
    in_last   = 1'b0;
    chk("stray_last_ready", 32'(in_ready), 32'd1);
    chk("stray_last_valid", 32'(out_valid), 32'd0);
    beat(16'h0000, 1'b1);
    finish_group("rnd_pos", 8'h06, 1'b0);

    // (-100+8)>>>4 = -6
    cfg_shift = 4'd4; cfg_relu = 1'b0;
    beat(16'h8064, 1'b1);
    finish_group("rnd_neg", 8'h86, 1'b0);

    cfg_shift = 4'd0;
    beat(16'h8000, 1'b1);
    finish_group("neg_zero", 8'h00, 1'b0);

    beat(16'h3FFF, 1'b1);
    finish_group("sat_pos", 8'h7F, 1'b0);

    beat(16'hBFFF, 1'b1);
    finish_group("sat_neg", 8'hFF, 1'b0);

    // -16383 + 1 with ReLU latched on the first beat
    cfg_relu = 1'b1;
    beat(16'hBFFF, 1'b0);
    cfg_relu = 1'b0;
    beat(16'h0001, 1'b1);
    finish_group("relu", 8'h00, 1'b0);

    // 600 * 16383 = 9829800 exceeds 8388607
    for (int i = 0; i < 600; i++) begin
      beat(16'h3FFF, (i == 599));
    end
    chk("clamp_rqnt_valid", 32'(out_valid), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_data", 32'(out_data), 32'h7F);
      chk("bp_ovf", 32'(acc_ovf), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);

    beat(16'h0001, 1'b1);
    finish_group("after_clamp", 8'h01, 1'b0);

    // Back-to-back groups with the consumer always ready
    out_ready = 1'b1;
    in_valid  = 1'b1; in_data = 16'h0003; in_last = 1'b1;
    tick();
    in_data = 16'h8002;
    chk("b2b_gap1_ready", 32'(in_ready), 32'd0);
    chk("b2b_gap1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("b2b_gap2_ready", 32'(in_ready), 32'd0);
    chk("b2b_first_valid", 32'(out_valid), 32'd1);
    chk("b2b_first_data", 32'(out_data), 32'h03);
    tick();
    chk("b2b_accept_ready", 32'(in_ready), 32'd1);
    chk("b2b_accept_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_data = 16'h0000;
    chk("b2b_second_rqnt", 32'(in_ready), 32'd0);
    tick();
    chk("b2b_second_valid", 32'(out_valid), 32'd1);
    chk("b2b_second_data", 32'(out_data), 32'h82);
    tick();
    out_ready = 1'b0;
    chk("b2b_second_drop", 32'(out_valid), 32'd0);

    // Reset discards a partial group
    beat(16'h0010, 1'b0);
    beat(16'h0010, 1'b0);
    beat(16'h0010, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'h00);
    chk("mid_rst_ovf", 32'(acc_ovf), 32'd0);
    beat(16'h0007, 1'b1);
    finish_group("post_rst", 8'h07, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
